quadram_dma: RTL



---
 rtl/quadram_pkg.sv | 12 +
 rtl/quadram_dma_fifo.sv | 46 ++++
 rtl/quadram_dma.sv | 94 +++++++++
 3 files changed

// File: rtl/quadram_pkg.sv
// quadram_pkg: shared constants and types for the quad-bank scratch memory DMA.
package quadram_pkg;
  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 32;
  localparam int RD_FIFO_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} dma_state_t;
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] len;
  } dma_cmd_t;
endpackage

// File: rtl/quadram_dma_fifo.sv
// quadram_dma_fifo: small synchronous FIFO; push is accepted when full if a pop happens in the same cycle.
module quadram_dma_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o = mem_q[rp_q];
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop = pop_i & ~empty_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q <= nxt(wp_q);
      end
      if (do_pop) rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/quadram_dma.sv
// quadram_dma: burst initiator for the 2048x32 scratch memory; streams write data in
// and read data out through a small return FIFO with full backpressure.
module quadram_dma #(
  parameter int ADDR_WIDTH = quadram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = quadram_pkg::DATA_WIDTH,
  parameter int RD_FIFO_DEPTH = quadram_pkg::RD_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ADDR_WIDTH-1:0]   cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  import quadram_pkg::dma_state_t, quadram_pkg::IDLE, quadram_pkg::WRITE, quadram_pkg::READ, quadram_pkg::DRAIN;
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);
  dma_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, rem_q, rem_d;
  logic inflight_q, done_q, done_d;
  logic [CW-1:0] occ;
  logic fifo_empty, fifo_full;
  logic hs, wr_acc, pop, issue, adv, last;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign wr_ready = state_q == WRITE;
  assign hs = cmd_valid & cmd_ready;
  assign wr_acc = wr_ready & wr_valid;
  assign rd_valid = ~fifo_empty;
  assign pop = rd_valid & rd_ready;
  // Never let buffered plus outstanding words exceed the FIFO, counting this cycle's pop as free space.
  assign issue = (state_q == READ) && (int'(occ) + int'(inflight_q) < RD_FIFO_DEPTH + int'(pop));
  assign adv = wr_acc | issue;
  assign last = rem_q == '0;
  assign mem_en = adv;
  assign mem_we = {(DATA_WIDTH/8){wr_acc}};
  assign mem_addr = (state_q == WRITE || state_q == READ) ? ptr_q : '0;
  assign mem_din = wr_ready ? wr_data : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    done_d = 1'b0;
    if (hs) begin
      state_d = cmd_write ? WRITE : READ;
      ptr_d = cmd_addr;
      rem_d = cmd_len;
    end
    if (adv) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      rem_d = rem_q - ADDR_WIDTH'(1);
      state_d = last ? (wr_acc ? IDLE : DRAIN) : state_q;
      done_d = wr_acc & last;
    end
    if (state_q == DRAIN && fifo_empty && !inflight_q) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rem_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      inflight_q <= issue;
      done_q <= done_d;
    end
  end
  quadram_dma_fifo #(.DEPTH(RD_FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(inflight_q), .din_i(mem_dout), .pop_i(pop),
    .dout_o(rd_data), .full_o(fifo_full), .empty_o(fifo_empty), .count_o(occ)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(inflight_q && fifo_full && !pop));
endmodule
